conv_output_streamer: RTL and testbench
=======================================

Name: conv_output_streamer

Overview:
Reads a complete flattened output tensor, as produced by the conv2d/conv3x3 stages, and serialises it into one element per cycle over a valid/ready stream. Each element carries its batch/channel/row/column coordinates and end-of-row/end-of-tensor markers. It sits between a convolution stage and downstream element-wise logic (residual add, activation, memory writer). It is the reader of the flat tensor bus that the convolution stages write.

Parameters:
BATCH_SIZE, 1, batches in the tensor
OUT_CHANNELS, 1, channels per batch
OUT_HEIGHT, 4, rows per channel
OUT_WIDTH, 4, columns per row
DATA_WIDTH, 32, bits per element; the value is opaque and is never interpreted arithmetically

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  tensor_flat holds a complete tensor
in_ready  out  1  block can capture a tensor; high only in IDLE
tensor_flat  in  N*DATA_WIDTH  flat tensor, where N = BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH
out_valid  out  1  out_* fields hold a valid element
out_ready  in  1  downstream accepts the element
out_data  out  DATA_WIDTH  element value
out_batch  out  BW  batch index; BW = max(1, clog2(BATCH_SIZE))
out_chan  out  CW  channel index; CW = max(1, clog2(OUT_CHANNELS))
out_row  out  RW  row index; RW = max(1, clog2(OUT_HEIGHT))
out_col  out  LW  column index; LW = max(1, clog2(OUT_WIDTH))
out_last_row  out  1  element is the last column of its row
out_last  out  1  element is the final element of the tensor
busy  out  1  high in STREAM

Behaviour:
- Element layout: flat index i = ((b*OUT_CHANNELS + c)*OUT_HEIGHT + h)*OUT_WIDTH + w. The element occupies tensor_flat[i*DATA_WIDTH +: DATA_WIDTH]. Streaming order is ascending i.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - STREAM: in_ready=0, out_valid=1.
- IDLE->STREAM on in_valid&&in_ready. The whole tensor_flat is registered into a buffer and all indices are cleared. out_valid rises the following cycle with element 0, so capture-to-first-element latency is 1 cycle.
- Each out_valid&&out_ready handshake advances to the next element. The buffer shifts down by DATA_WIDTH, and out_data is always buffer[DATA_WIDTH-1:0].
- Index counters are nested. col wraps at OUT_WIDTH-1 and carries to row. row wraps to chan. chan wraps to batch.
- out_last_row = (col==OUT_WIDTH-1). out_last = all indices at their maximum. Both are valid only while out_valid=1 and are 0 otherwise.
- Stall rule: while out_valid && !out_ready, out_data, all indices and all flags stay unchanged.
- STREAM->IDLE on the handshake of the out_last element. in_ready is high the next cycle.
- Throughput: N+1 cycles per tensor with out_ready held high. There is one bubble cycle between tensors, and capture does not overlap streaming.
- in_valid while in STREAM is ignored. The buffer is not disturbed.
- N==1: the first element has out_last_row=1 and out_last=1, and the block returns to IDLE after one handshake.
- Reset (including mid-stream), effective on the next cycle:
  - state=IDLE, out_valid=0, in_ready=1, busy=0.
  - All indices 0, out_last=0, out_last_row=0, buffer and out_data 0.
  - Any partially streamed tensor is discarded.

Decomposition:
- Shared package conv_pkg holds:
  - function clog2_min1 (index widths);
  - function flat_index(b,c,h,w) defining the element layout, shared with conv2d test benches;
  - state enum {IDLE, STREAM}.
- One sub-module, tensor_index_counter. It holds the nested batch/chan/row/col counters with an advance input and synchronous clear, and produces the indices, last_row and last. The streamer top holds the FSM, the shift buffer and the handshake.

Test Plan:
- Reset: hold rst for 2 cycles -> out_valid=0, in_ready=1, busy=0, out_data=0, all indices 0.
- Defaults (1x1x4x4), element i = i+1, out_ready=1:
  - capture at cycle 0;
  - out_valid on cycles 1..16 with out_data 1..16 and (row,col) = (0,0)..(3,3);
  - out_last_row on values 4, 8, 12, 16; out_last only on 16;
  - in_ready high at cycle 17.
- Backpressure: same tensor with out_ready toggling 1,0,1,0 -> every stalled cycle holds out_data and indices stable; all 16 values arrive in order, with the last handshake at cycle 31.
- Ignored input: during STREAM, drive in_valid=1 with all elements 0xDEADBEEF -> the stream still delivers 1..16 and in_ready stays 0 until done.
- Reset mid-stream: assert rst after the 5th handshake -> next cycle out_valid=0, in_ready=1. A new tensor of i+100 then streams from 100 with indices restarting at 0.
- BATCH_SIZE=2, OUT_CHANNELS=2, OUT_HEIGHT=OUT_WIDTH=2, element i=i:
  - 16 elements in order 0..15;
  - (b,c,h,w) for element 5 is (0,1,0,1), and for element 12 is (1,1,0,0);
  - out_last only on element 15.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tensor pipeline: index widths, the
// flat element layout and the streamer state encoding.
package conv_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } stream_state_e;

    // Index width for a dimension; a single-entry dimension still gets one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? int'($clog2(v)) : 1;
    endfunction

    // Position of element (b,c,h,w) in a flattened tensor.
    function automatic int unsigned flat_index(
        input int unsigned b,
        input int unsigned c,
        input int unsigned h,
        input int unsigned w,
        input int unsigned channels,
        input int unsigned height,
        input int unsigned width
    );
        return ((b * channels + c) * height + h) * width + w;
    endfunction

endpackage

// File: rtl/tensor_index_counter.sv
// Nested batch/channel/row/column counters that track the coordinates of the
// element currently presented by the streamer.
module tensor_index_counter
    import conv_pkg::*;
#(
    parameter int unsigned BATCH_SIZE   = 1,
    parameter int unsigned OUT_CHANNELS = 1,
    parameter int unsigned OUT_HEIGHT   = 4,
    parameter int unsigned OUT_WIDTH    = 4,
    localparam int unsigned BW = clog2_min1(BATCH_SIZE),
    localparam int unsigned CW = clog2_min1(OUT_CHANNELS),
    localparam int unsigned RW = clog2_min1(OUT_HEIGHT),
    localparam int unsigned LW = clog2_min1(OUT_WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [BW-1:0] batch,
    output logic [CW-1:0] chan,
    output logic [RW-1:0] row,
    output logic [LW-1:0] col,
    output logic          last_row,
    output logic          last
);

    localparam logic [BW-1:0] BatchMax = BW'(BATCH_SIZE - 1);
    localparam logic [CW-1:0] ChanMax  = CW'(OUT_CHANNELS - 1);
    localparam logic [RW-1:0] RowMax   = RW'(OUT_HEIGHT - 1);
    localparam logic [LW-1:0] ColMax   = LW'(OUT_WIDTH - 1);

    logic [BW-1:0] batch_q, batch_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [RW-1:0] row_q, row_d;
    logic [LW-1:0] col_q, col_d;

    // Ripple-carry advance: column wraps into row, row into channel, channel into batch.
    always_comb begin
        batch_d = batch_q;
        chan_d  = chan_q;
        row_d   = row_q;
        col_d   = col_q;
        if (clear) begin
            batch_d = '0;
            chan_d  = '0;
            row_d   = '0;
            col_d   = '0;
        end else if (advance) begin
            if (col_q == ColMax) begin
                col_d = '0;
                if (row_q == RowMax) begin
                    row_d = '0;
                    if (chan_q == ChanMax) begin
                        chan_d  = '0;
                        batch_d = (batch_q == BatchMax) ? '0 : batch_q + BW'(1);
                    end else begin
                        chan_d = chan_q + CW'(1);
                    end
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + LW'(1);
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            batch_q <= '0;
            chan_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            batch_q <= batch_d;
            chan_q  <= chan_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign batch    = batch_q;
    assign chan     = chan_q;
    assign row      = row_q;
    assign col      = col_q;
    assign last_row = (col_q == ColMax);
    assign last     = (col_q == ColMax) && (row_q == RowMax) &&
                      (chan_q == ChanMax) && (batch_q == BatchMax);

endmodule

// File: rtl/conv_output_streamer.sv
// Captures a whole flattened tensor and replays it one element per cycle over a
// valid/ready stream, tagging each element with its coordinates.
module conv_output_streamer
    import conv_pkg::*;
#(
    parameter int unsigned BATCH_SIZE   = 1,
    parameter int unsigned OUT_CHANNELS = 1,
    parameter int unsigned OUT_HEIGHT   = 4,
    parameter int unsigned OUT_WIDTH    = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    localparam int unsigned N  = BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH,
    localparam int unsigned BW = clog2_min1(BATCH_SIZE),
    localparam int unsigned CW = clog2_min1(OUT_CHANNELS),
    localparam int unsigned RW = clog2_min1(OUT_HEIGHT),
    localparam int unsigned LW = clog2_min1(OUT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] tensor_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [BW-1:0]           out_batch,
    output logic [CW-1:0]           out_chan,
    output logic [RW-1:0]           out_row,
    output logic [LW-1:0]           out_col,
    output logic                    out_last_row,
    output logic                    out_last,
    output logic                    busy
);

    stream_state_e           state_q, state_d;
    logic [N*DATA_WIDTH-1:0] buf_q, buf_d;
    logic                    capture;
    logic                    advance;
    logic                    cnt_last_row;
    logic                    cnt_last;

    // Capture in IDLE; in STREAM shift one element out per handshake.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        capture = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    capture = 1'b1;
                    buf_d   = tensor_flat;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (out_ready) begin
                    advance = 1'b1;
                    buf_d   = buf_q >> DATA_WIDTH;
                    if (cnt_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and shift buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    tensor_index_counter #(
        .BATCH_SIZE  (BATCH_SIZE),
        .OUT_CHANNELS(OUT_CHANNELS),
        .OUT_HEIGHT  (OUT_HEIGHT),
        .OUT_WIDTH   (OUT_WIDTH)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .clear   (capture),
        .advance (advance),
        .batch   (out_batch),
        .chan    (out_chan),
        .row     (out_row),
        .col     (out_col),
        .last_row(cnt_last_row),
        .last    (cnt_last)
    );

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StStream);
    assign busy         = out_valid;
    assign out_data     = buf_q[DATA_WIDTH-1:0];
    // Flags are only meaningful alongside a valid element.
    assign out_last_row = out_valid && cnt_last_row;
    assign out_last     = out_valid && cnt_last;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Scoreboard bench for conv_output_streamer: a 1x1x4x4 instance and a 2x2x2x2
// instance share one stimulus/monitor path selected by sel.
module tb_conv_output_streamer;
    import conv_pkg::*;

    typedef struct {
        int data;
        int b;
        int c;
        int h;
        int w;
        int lr;
        int last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         toggle = 1'b0;
    logic [511:0] tensor = '0;

    logic        a_in_ready, a_out_valid, a_last_row, a_last, a_busy;
    logic [31:0] a_data;
    logic [0:0]  a_batch, a_chan;
    logic [1:0]  a_row, a_col;
    logic        b_in_ready, b_out_valid, b_last_row, b_last, b_busy;
    logic [31:0] b_data;
    logic [0:0]  b_batch, b_chan, b_row, b_col;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   cap_cyc = 0;
    int   last_hs_cyc = 0;
    int   hs_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    conv_output_streamer u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid && !sel),
        .in_ready    (a_in_ready),
        .tensor_flat (tensor),
        .out_valid   (a_out_valid),
        .out_ready   (out_ready),
        .out_data    (a_data),
        .out_batch   (a_batch),
        .out_chan    (a_chan),
        .out_row     (a_row),
        .out_col     (a_col),
        .out_last_row(a_last_row),
        .out_last    (a_last),
        .busy        (a_busy)
    );

    conv_output_streamer #(
        .BATCH_SIZE  (2),
        .OUT_CHANNELS(2),
        .OUT_HEIGHT  (2),
        .OUT_WIDTH   (2)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid && sel),
        .in_ready    (b_in_ready),
        .tensor_flat (tensor),
        .out_valid   (b_out_valid),
        .out_ready   (out_ready),
        .out_data    (b_data),
        .out_batch   (b_batch),
        .out_chan    (b_chan),
        .out_row     (b_row),
        .out_col     (b_col),
        .out_last_row(b_last_row),
        .out_last    (b_last),
        .busy        (b_busy)
    );

    // Selected instance's outputs, zero-extended to common widths.
    logic        m_in_ready, m_valid, m_last_row, m_last, m_busy;
    logic [31:0] m_data;
    logic [1:0]  m_b, m_c, m_h, m_w;
    assign m_in_ready = sel ? b_in_ready : a_in_ready;
    assign m_valid    = sel ? b_out_valid : a_out_valid;
    assign m_last_row = sel ? b_last_row : a_last_row;
    assign m_last     = sel ? b_last : a_last;
    assign m_busy     = sel ? b_busy : a_busy;
    assign m_data     = sel ? b_data : a_data;
    assign m_b        = sel ? 2'(b_batch) : 2'(a_batch);
    assign m_c        = sel ? 2'(b_chan) : 2'(a_chan);
    assign m_h        = sel ? 2'(b_row) : 2'(a_row);
    assign m_w        = sel ? 2'(b_col) : 2'(a_col);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Downstream ready: constant high, or high on odd cycles after capture.
    always @(posedge clk) begin
        #1;
        out_ready = toggle ? (((cyc - cap_cyc) % 2) == 1) : 1'b1;
    end

    // Monitor: sample mid-cycle, score handshakes and check stall stability.
    logic        stall_q = 1'b0;
    logic [31:0] hold_data;
    logic [7:0]  hold_idx;
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (in_valid && m_in_ready) cap_cyc = cyc;
            if (stall_q && m_valid) begin
                check_eq("stall_data", m_data, hold_data);
                check_eq("stall_idx", 32'({m_b, m_c, m_h, m_w}), 32'(hold_idx));
            end
            if (!m_valid) begin
                check_eq("idle_flags", 32'({m_last_row, m_last}), 32'd0);
            end
            if (m_valid && out_ready) begin
                exp_t e;
                hs_total++;
                last_hs_cyc = cyc;
                check_eq("in_ready_streaming", 32'(m_in_ready), 32'd0);
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("data", m_data, 32'(e.data));
                    check_eq("batch", 32'(m_b), 32'(e.b));
                    check_eq("chan", 32'(m_c), 32'(e.c));
                    check_eq("row", 32'(m_h), 32'(e.h));
                    check_eq("col", 32'(m_w), 32'(e.w));
                    check_eq("last_row", 32'(m_last_row), 32'(e.lr));
                    check_eq("last", 32'(m_last), 32'(e.last));
                end
            end
            stall_q   = m_valid && !out_ready;
            hold_data = m_data;
            hold_idx  = {m_b, m_c, m_h, m_w};
        end
    end

    // Build the tensor for the selected instance and queue its expected stream.
    task automatic load_tensor(input int base);
        int nb, nc, nh, nw, i;
        nb = sel ? 2 : 1;
        nc = sel ? 2 : 1;
        nh = sel ? 2 : 4;
        nw = sel ? 2 : 4;
        tensor = '0;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < nc; c++)
                for (int h = 0; h < nh; h++)
                    for (int w = 0; w < nw; w++) begin
                        i = int'(flat_index(b, c, h, w, nc, nh, nw));
                        tensor[i*32 +: 32] = 32'(base + i);
                        sb.push_back('{base + i, b, c, h, w, int'(w == nw - 1),
                                       int'(i == nb * nc * nh * nw - 1)});
                    end
    endtask

    task automatic capture();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_total < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("hs_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic wait_idle(input int exp_last_rel);
        int n = 0;
        while (!m_in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("idle_timeout", 32'(n < 200), 32'd1);
        check_eq("last_hs_cycle", 32'(last_hs_cyc - cap_cyc), 32'(exp_last_rel));
        check_eq("in_ready_cycle", 32'(cyc - cap_cyc), 32'(exp_last_rel + 1));
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_state();
        check_eq("rst_out_valid", 32'(m_valid), 32'd0);
        check_eq("rst_in_ready", 32'(m_in_ready), 32'd1);
        check_eq("rst_busy", 32'(m_busy), 32'd0);
        check_eq("rst_data", m_data, 32'd0);
        check_eq("rst_idx", 32'({m_b, m_c, m_h, m_w}), 32'd0);
        check_eq("rst_flags", 32'({m_last_row, m_last}), 32'd0);
    endtask

    initial begin
        int h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();

        // Full-rate stream of 1..16.
        load_tensor(1);
        capture();
        wait_idle(16);

        // Backpressure: ready toggles 1,0,1,0 from the first valid cycle.
        toggle = 1'b1;
        load_tensor(1);
        capture();
        wait_idle(31);
        toggle = 1'b0;
        @(posedge clk);
        #1;

        // New input offered during STREAM must be ignored.
        h0 = hs_total;
        load_tensor(1);
        capture();
        tensor   = {16{32'hDEADBEEF}};
        in_valid = 1'b1;
        wait_hs(h0 + 15);
        in_valid = 1'b0;
        wait_idle(16);

        // Reset in the middle of a stream discards the remainder.
        h0 = hs_total;
        load_tensor(1);
        capture();
        wait_hs(h0 + 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check_reset_state();
        load_tensor(100);
        capture();
        wait_idle(16);

        // 2x2x2x2 instance, element i = i.
        sel = 1'b1;
        @(posedge clk);
        #1;
        load_tensor(0);
        capture();
        wait_idle(16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
